// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: accepts fetch PCs, strobes a one-cycle-latency instruction
// memory, and buffers {pc, instr, misalign} in an in-order queue for decode.
// Optional feature macro: FETCH_PERF_CNT_EN adds FETCH_CNT and FLUSH_DROP_CNT.
module instr_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC_IN,
  input  logic              PC_VALID,
  output logic              PC_READY,
  input  logic              FLUSH,
  output logic              IMEM_EN,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic [DATA_W-1:0] IMEM_RDATA,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] INSTR_PC,
  output logic              INSTR_MISALIGN
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       FETCH_CNT,
  output logic [31:0]       FLUSH_DROP_CNT
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]  FULL_OCC = (CNT_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              misalign;
  } entry_t;

  // Stage register S1: the fetch whose memory data arrives this cycle.
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_pc;
  logic              s1_mis;

  entry_t            queue_mem [DEPTH];
  entry_t            head;
  entry_t            last_q;
  entry_t            wr_entry;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ;

  logic accept;
  logic pc_mis;
  logic push;
  logic pop;

  // S1 reserves a queue slot, so occupancy counts it; only registered state feeds it.
  assign occ      = {1'b0, count} + {{CNT_W{1'b0}}, s1_valid};
  assign PC_READY = !RST && !FLUSH && (occ < FULL_OCC);
  assign accept   = PC_VALID && PC_READY;
  assign pc_mis   = (PC_IN[1:0] != 2'b00);

  // Misaligned fetches never touch memory; they retire as a NOP.
  assign IMEM_EN   = accept && !pc_mis;
  assign IMEM_ADDR = PC_IN;

  assign INSTR_VALID = (count != '0);
  assign push        = s1_valid && !RST && !FLUSH;
  assign pop         = INSTR_VALID && INSTR_READY && !RST && !FLUSH;

  assign head     = queue_mem[rd_ptr];
  assign wr_entry = '{pc: s1_pc, instr: (s1_mis ? NOP : IMEM_RDATA), misalign: s1_mis};

  // When empty, the outputs show the most recently consumed entry.
  assign INSTR          = INSTR_VALID ? head.instr    : last_q.instr;
  assign INSTR_PC       = INSTR_VALID ? head.pc       : last_q.pc;
  assign INSTR_MISALIGN = INSTR_VALID ? head.misalign : last_q.misalign;

  // Control state: S1, pointers, count and the held head copy.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      s1_valid <= 1'b0;
      s1_pc    <= '0;
      s1_mis   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      last_q   <= '0;
    end else if (FLUSH) begin
      s1_valid <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pc  <= PC_IN;
        s1_mis <= pc_mis;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last_q <= head;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage write at the tail.
  always_ff @(posedge CLK) begin
    // NOTE: the storage array is deliberately not reset; count and pointers
    // define which entries are meaningful, so stale contents are never visible.
    if (push) queue_mem[wr_ptr] <= wr_entry;
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: queue writes and entries discarded by redirects.
  always_ff @(posedge CLK) begin
    if (RST) begin
      FETCH_CNT      <= '0;
      FLUSH_DROP_CNT <= '0;
    end else begin
      if (push)  FETCH_CNT      <= FETCH_CNT + 32'd1;
      if (FLUSH) FLUSH_DROP_CNT <= FLUSH_DROP_CNT + 32'(occ);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: scoreboard of accepted fetches
// compared in order against decoder-side pops, plus directed timing checks.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_drop_cnt;
`endif

  instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK            (clk),
    .RST            (rst),
    .PC_IN          (pc_in),
    .PC_VALID       (pc_valid),
    .PC_READY       (pc_ready),
    .FLUSH          (flush),
    .IMEM_EN        (imem_en),
    .IMEM_ADDR      (imem_addr),
    .IMEM_RDATA     (imem_rdata),
    .INSTR_VALID    (instr_valid),
    .INSTR_READY    (instr_ready),
    .INSTR          (instr),
    .INSTR_PC       (instr_pc),
    .INSTR_MISALIGN (instr_misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FETCH_CNT      (fetch_cnt),
    .FLUSH_DROP_CNT (flush_drop_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pops   = 0;
  int          acc;
  logic [31:0] base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word index + 1, times 0x11 (0x0 -> 0x11, 0x4 -> 0x22 ...).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  // One-cycle-latency memory; garbage when not strobed.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
    else         imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_pc_ready", pc_ready, 1'b0);
      check("rst_imem_en", imem_en, 1'b0);
      sb.delete();
    end else begin
      check("imem_en", imem_en, pc_valid && pc_ready && (pc_in[1:0] == 2'b00));
      if (imem_en) check("imem_addr", imem_addr, pc_in);
      if (flush) begin
        check("flush_pc_ready", pc_ready, 1'b0);
        sb.delete();
      end else begin
        if (instr_valid && instr_ready) begin
          check("sb_nonempty", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("head_pc", instr_pc, e.pc);
            check("head_instr", instr, e.instr);
            check("head_mis", instr_misalign, e.mis);
            n_pops++;
          end
        end
        if (pc_valid && pc_ready) begin
          e.pc    = pc_in;
          e.mis   = (pc_in[1:0] != 2'b00);
          e.instr = e.mis ? 32'h0000_0013 : mem_word(pc_in);
          sb.push_back(e);
        end
      end
    end
  end

  // Offer PCs for n cycles; the offered PC advances only after an accept.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      pc_valid = 1'b1;
      pc_in    = base + 32'(4 * acc);
      @(negedge clk);
      if (pc_ready) acc++;
    end
  endtask

  task automatic drain(input string tag);
    pc_valid    = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 20 && instr_valid; k++) @(negedge clk);
    @(negedge clk);
    check(tag, instr_valid, 1'b0);
  endtask

  initial begin
    int pops0;
    rst = 1'b1; pc_valid = 1'b0; pc_in = 32'h40; flush = 1'b0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 pc_valid = 1'b1;
    @(negedge clk);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_misalign", instr_misalign, 1'b0);
    check("rst_imem_addr", imem_addr, 32'h40);
    @(posedge clk); #1;
    rst = 1'b0; pc_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst", pc_ready, 1'b1);

    // Streaming: 0x0..0xC back to back, decoder always ready.
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pc_valid = (i < 4);
      pc_in    = 32'(4 * i);
      @(negedge clk);
      if (i < 4) check("stream_ready", pc_ready, 1'b1);
      if (i < 2) check("stream_latency", instr_valid, 1'b0);
      else begin
        check("stream_valid", instr_valid, 1'b1);
        check("stream_pc", instr_pc, 32'(4 * (i - 2)));
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("stream_done", instr_valid, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, 32'd4);
`endif

    // Backpressure: exactly DEPTH accepts, then release.
    instr_ready = 1'b0; base = 32'h0; acc = 0;
    run(8);
    check("bp_accepts", acc, 4);
    check("bp_ready_low", pc_ready, 1'b0);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    pc_in = base + 32'(4 * acc);
    @(negedge clk);
    check("bp_head_first", instr_pc, 32'h0);
    check("bp_ready_pop_cycle", pc_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_after_pop", pc_ready, 1'b1);
    if (pc_ready) acc++;
    run(6);
    drain("bp_drain");

    // Misaligned fetch becomes a NOP without a memory strobe.
    @(posedge clk); #1;
    pc_valid = 1'b1; pc_in = 32'h6;
    @(negedge clk);
    check("mis_accept", pc_ready, 1'b1);
    check("mis_no_imem", imem_en, 1'b0);
    @(posedge clk); #1;
    pc_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_valid", instr_valid, 1'b1);
    check("mis_instr", instr, 32'h0000_0013);
    check("mis_pc", instr_pc, 32'h6);
    check("mis_flag", instr_misalign, 1'b1);
    drain("mis_drain");

    // Flush with 3 queued and 1 in S1; a simultaneous pop is ignored.
    instr_ready = 1'b0; base = 32'h300; acc = 0;
    run(4);
    @(posedge clk); #1;
    flush = 1'b1; instr_ready = 1'b1; pc_valid = 1'b1; pc_in = 32'h310;
    @(negedge clk);
    check("flush_no_imem", imem_en, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h100;
    @(negedge clk);
    check("flush_empty", instr_valid, 1'b0);
    check("flush_ready", pc_ready, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("flush_drop_cnt", flush_drop_cnt, 32'd4);
`endif
    pops0 = n_pops;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("flush_single_pop", n_pops - pops0, 1);
    check("flush_idle", instr_valid, 1'b0);

    // Reset mid-stream with entries pending.
    instr_ready = 1'b0; base = 32'h400; acc = 0;
    run(3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_valid", instr_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; pc_valid = 1'b0;
    @(negedge clk);
    check("midrst_ready", pc_ready, 1'b1);
    check("midrst_empty", instr_valid, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("midrst_fetch_cnt", fetch_cnt, 32'd0);
    check("midrst_drop_cnt", flush_drop_cnt, 32'd0);
`endif
    check("sb_empty_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
